// File: rtl/permutation_sequencer.sv
// permutation_sequencer: drives sel/round/state-enable of the Ascon permutation
// datapath for one p^a or p^b run per accepted start, then pulses done.
module permutation_sequencer #(
   parameter int ROUNDS_A = 12,
   parameter int ROUNDS_B = 6
) (
   input  logic       clock_i,
   input  logic       resetb_i,
   input  logic       start_i,
   input  logic       mode_i,
   output logic       sel_o,
   output logic [3:0] round_o,
   output logic       en_reg_state_o,
   output logic       busy_o,
   output logic       done_o
);

   // Reject illegal round counts at elaboration instead of clamping them.
   if (ROUNDS_A < 1 || ROUNDS_A > 12) begin : g_bad_rounds_a
      $error("permutation_sequencer: ROUNDS_A must be in 1..12");
   end
   if (ROUNDS_B < 1 || ROUNDS_B > ROUNDS_A) begin : g_bad_rounds_b
      $error("permutation_sequencer: ROUNDS_B must be in 1..ROUNDS_A");
   end

   // Ascon constant table: an N-round permutation uses indices 12-N .. 11.
   localparam logic [3:0] START_A    = 4'(12 - ROUNDS_A);
   localparam logic [3:0] START_B    = 4'(12 - ROUNDS_B);
   localparam logic [3:0] LAST_ROUND = 4'd11;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] round_q, round_d;
   logic       sel_q, sel_d;
   logic       en_q, en_d;
   logic       busy_q, busy_d;
   logic       done_q, done_d;

   // Next state and next registered outputs; every output comes straight from a flop.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path leaves it
      // unassigned and no latch is inferred.
      state_d = state_q;
      round_d = round_q;
      sel_d   = 1'b0;
      en_d    = 1'b0;
      busy_d  = 1'b0;
      done_d  = 1'b0;
      case (state_q)
         IDLE, DONE: begin
            if (start_i) begin
               // First round loads external state_i, so the mux stays at 0.
               state_d = RUN;
               round_d = mode_i ? START_B : START_A;
               en_d    = 1'b1;
               busy_d  = 1'b1;
            end else begin
               state_d = IDLE;
            end
         end
         RUN: begin
            if (round_q > LAST_ROUND) begin
               // Unreachable counter value: abandon the run quietly.
               state_d = IDLE;
            end else if (round_q == LAST_ROUND) begin
               state_d = DONE;
               done_d  = 1'b1;
            end else begin
               round_d = round_q + 4'd1;
               sel_d   = 1'b1;
               en_d    = 1'b1;
               busy_d  = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // State, round counter and output registers with asynchronous reset.
   always_ff @(posedge clock_i or posedge resetb_i) begin
      if (resetb_i) begin
         state_q <= IDLE;
         round_q <= 4'd0;
         sel_q   <= 1'b0;
         en_q    <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments so every flop samples pre-edge values.
         state_q <= state_d;
         round_q <= round_d;
         sel_q   <= sel_d;
         en_q    <= en_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
      end
   end

   assign sel_o          = sel_q;
   assign round_o        = round_q;
   assign en_reg_state_o = en_q;
   assign busy_o         = busy_q;
   assign done_o         = done_q;

endmodule

// File: tb/tb_permutation_sequencer.sv
// tb_permutation_sequencer: checks two instances (default rounds and 8/3 rounds)
// against a position-in-schedule reference model, plus table vectors and corner cases.
module tb_permutation_sequencer;

   localparam int RA0 = 12;
   localparam int RB0 = 6;
   localparam int RA1 = 8;
   localparam int RB1 = 3;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       mode;
   logic       sel_a, en_a, busy_a, done_a;
   logic [3:0] round_a;
   logic       sel_b, en_b, busy_b, done_b;
   logic [3:0] round_b;

   int n_checks = 0;
   int n_pass   = 0;

   permutation_sequencer u_dut_a (
      .clock_i(clk), .resetb_i(rst), .start_i(start), .mode_i(mode),
      .sel_o(sel_a), .round_o(round_a), .en_reg_state_o(en_a),
      .busy_o(busy_a), .done_o(done_a)
   );

   permutation_sequencer #(.ROUNDS_A(RA1), .ROUNDS_B(RB1)) u_dut_b (
      .clock_i(clk), .resetb_i(rst), .start_i(start), .mode_i(mode),
      .sel_o(sel_b), .round_o(round_b), .en_reg_state_o(en_b),
      .busy_o(busy_b), .done_o(done_b)
   );

   always #5 clk = ~clk;

   // Reference model: pos = cycles since the accepting edge (0 = idle),
   // pos 1..n are round cycles, pos n+1 is the done cycle.
   typedef struct {
      int pos;
      int n;
      int last;
   } model_t;

   model_t mdl_a, mdl_b;

   function automatic model_t model_step(model_t s, logic st, logic md, int na, int nb);
      model_t r;
      r = s;
      if ((s.pos == 0 || s.pos == s.n + 1) && st) begin
         r.n   = md ? nb : na;
         r.pos = 1;
      end else if (s.pos >= 1 && s.pos <= s.n) begin
         r.pos = s.pos + 1;
      end else begin
         r.pos = 0;
      end
      if (r.pos >= 1 && r.pos <= r.n) r.last = 12 - r.n + r.pos - 1;
      else if (r.pos == r.n + 1)      r.last = 11;
      return r;
   endfunction

   // Expected {sel, round[3:0], en, busy, done}.
   function automatic logic [7:0] model_out(model_t s);
      if (s.pos >= 1 && s.pos <= s.n) return {1'(s.pos > 1), 4'(s.last), 3'b110};
      if (s.pos == s.n + 1)           return {1'b0, 4'd11, 3'b001};
      return {1'b0, 4'(s.last), 3'b000};
   endfunction

   function automatic logic [7:0] pack_a();
      return {sel_a, round_a, en_a, busy_a, done_a};
   endfunction

   function automatic logic [7:0] pack_b();
      return {sel_b, round_b, en_b, busy_b, done_b};
   endfunction

   task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h", name, act, exp);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_checks++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic model_reset();
      mdl_a = '{pos: 0, n: 0, last: 0};
      mdl_b = '{pos: 0, n: 0, last: 0};
   endtask

   // One clock: advance both models with the inputs seen at the edge, then compare.
   task automatic tick();
      @(posedge clk);
      mdl_a = model_step(mdl_a, start, mode, RA0, RB0);
      mdl_b = model_step(mdl_b, start, mode, RA1, RB1);
      #1;
      check("outs_a", pack_a(), model_out(mdl_a));
      check("outs_b", pack_b(), model_out(mdl_b));
   endtask

   typedef struct {
      logic mode;
      int   first_a;
      int   lat_a;
      int   first_b;
      int   lat_b;
   } vec_t;

   vec_t vecs [3];

   // Single start pulse; mode flips during the run and must not matter.
   task automatic run_vec(input vec_t v);
      int k, da, db;
      start = 1'b1;
      mode  = v.mode;
      tick();
      start = 1'b0;
      mode  = ~v.mode;
      check_int("first_round_a", int'(round_a), v.first_a);
      check_int("first_round_b", int'(round_b), v.first_b);
      k  = 1;
      da = 0;
      db = 0;
      while (k < 20 && (da == 0 || db == 0)) begin
         tick();
         k++;
         if (done_a && da == 0) da = k;
         if (done_b && db == 0) db = k;
      end
      check_int("latency_a", da, v.lat_a);
      check_int("latency_b", db, v.lat_b);
      repeat (3) tick();
   endtask

   initial begin
      int k, nd, d1, d2, reached;
      vecs[0] = '{mode: 1'b0, first_a: 0, lat_a: 13, first_b: 4, lat_b: 9};
      vecs[1] = '{mode: 1'b1, first_a: 6, lat_a: 7,  first_b: 9, lat_b: 4};
      vecs[2] = '{mode: 1'b0, first_a: 0, lat_a: 13, first_b: 4, lat_b: 9};

      rst   = 1'b1;
      start = 1'b0;
      mode  = 1'b0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      check("reset_a", pack_a(), 8'h00);
      check("reset_b", pack_b(), 8'h00);
      rst = 1'b0;

      // Table-driven single permutations.
      for (int i = 0; i < 3; i++) run_vec(vecs[i]);

      // start held high for 20 cycles in p^b: dones at +7 and +14 only.
      start = 1'b1;
      mode  = 1'b1;
      nd = 0; d1 = 0; d2 = 0;
      for (int i = 1; i <= 20; i++) begin
         tick();
         if (done_a) begin
            nd++;
            if (nd == 1) d1 = i;
            if (nd == 2) d2 = i;
         end
      end
      start = 1'b0;
      check_int("held_done_count", nd, 2);
      check_int("held_done_1", d1, 7);
      check_int("held_done_2", d2, 14);
      repeat (12) tick();

      // start pulsed in the 4th RUN cycle of p^a is ignored.
      start = 1'b1;
      mode  = 1'b0;
      tick();
      start = 1'b0;
      repeat (3) tick();
      start = 1'b1;
      tick();
      start = 1'b0;
      nd = 0; d1 = 0;
      for (int i = 6; i <= 20; i++) begin
         tick();
         if (done_a) begin
            nd++;
            if (nd == 1) d1 = i;
         end
      end
      check_int("ignored_start_dones", nd, 1);
      check_int("ignored_start_latency", d1, 13);

      // Asynchronous reset mid-RUN at round 5.
      start = 1'b1;
      mode  = 1'b0;
      tick();
      start = 1'b0;
      reached = 0;
      k = 0;
      while (k < 15 && reached == 0) begin
         if (round_a == 4'd5 && busy_a) reached = 1;
         else begin
            tick();
            k++;
         end
      end
      check_int("reach_round5", reached, 1);
      #2 rst = 1'b1;
      #1;
      check("async_reset_a", pack_a(), 8'h00);
      check("async_reset_b", pack_b(), 8'h00);
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      nd = 0;
      for (int i = 0; i < 15; i++) begin
         tick();
         if (done_a || done_b) nd++;
      end
      check_int("no_done_after_abort", nd, 0);
      run_vec(vecs[0]);

      // Randomized stimulus against the model.
      for (int i = 0; i < 400; i++) begin
         start = ($urandom_range(0, 3) == 0);
         mode  = 1'($urandom_range(0, 1));
         tick();
      end
      start = 1'b0;
      repeat (15) tick();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
